hwag_cap_sync: RTL
==================

Name: hwag_cap_sync

Overview:
- Crank input front end that sits directly upstream of the angle generator.
- Conditions the raw VR-sensor comparator signal: synchronise, glitch-filter, select edge.
- Measures tooth period in clk cycles, validates it against min/max window, and finds the missing-tooth gap (60-2 wheel).
- Delivers tooth strobes, tooth index, period and sync status to the angle generator.

Parameters:
- CNT_W, 24, width of period counter and min/max compare values.
- TOOTH_W, 8, width of tooth index/count.
- FILT_W, 4, width of glitch-filter length.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- cap_in  input  1  raw VR comparator signal, asynchronous
- filt_len  input  FILT_W  filter length in clk cycles (0 = no filter)
- edge_sel  input  1  0 = rising edge is tooth, 1 = falling
- min_cap  input  CNT_W  minimum valid period
- max_cap  input  CNT_W  maximum period / stall timeout
- teeth_last  input  TOOTH_W  index of last tooth before gap (57 for 60-2)
- cap_out  output  1  filtered input level
- tooth_stb  output  1  one-cycle pulse per accepted tooth edge
- gap_stb  output  1  one-cycle pulse, coincident with tooth_stb, when the edge ends a gap
- tooth_idx  output  TOOTH_W  index of the tooth just accepted (0 = first after gap)
- tooth_period  output  CNT_W  period ending at the accepted edge
- sync  output  1  wheel position locked
- err_stb  output  1  one-cycle error pulse
- err_code  output  2  1 = short (noise), 2 = stall, 3 = tooth count mismatch; held until next error
- err_cnt  output  8  saturating error count (optional feature)

Behaviour:
- Reset values: cap_out 0; all strobes 0; tooth_idx 0; tooth_period 0; sync 0; err_code 0; err_cnt 0; FSM IDLE; counter 0.
- Sync: 2-FF synchroniser on cap_in.
- Filter: cap_out toggles when the synchronised input has differed from cap_out for filt_len consecutive cycles. filt_len=0 copies the synchroniser output.
- Edge: selected transition of cap_out, registered. Strobes assert 1 cycle after the cap_out change.
- Period counter:
  - counts clk cycles and saturates at all-ones;
  - on an accepted edge it restarts at 1;
  - tooth_period = cycles between consecutive accepted edges.
- Noise: edge with counter < min_cap is ignored. Counter keeps running; err_stb, code 1; no tooth_stb.
- Stall: counter reaches max_cap → err_stb, code 2; sync cleared; FSM to IDLE.
- Gap test: period > prev + (prev >> 1). prev = last accepted non-gap period.
- FSM:
  - IDLE: first accepted edge → FIRST. No tooth_stb.
  - FIRST: next edge stores prev → HUNT. tooth_stb, tooth_idx 0.
  - HUNT: a gap edge → SYNC, sync=1, tooth_idx 0, gap_stb. A non-gap edge updates prev; tooth_stb each edge.
  - SYNC: a non-gap edge increments tooth_idx. A gap edge:
    - when tooth_idx == teeth_last: tooth_idx 0, gap_stb;
    - otherwise: err code 3, sync 0, → HUNT.
  - SYNC: tooth_idx reaching teeth_last+1 without a gap → err code 3, sync 0, → HUNT.
- Simultaneous stall and edge in the same cycle: stall wins and the edge is discarded.
- tooth_period and tooth_idx update only with tooth_stb.
- An asynchronous rst at any time returns all state to reset values immediately.

Optional Feature:
- HWAG_CAP_ERR_CNT_EN defined: err_cnt increments on every err_stb and saturates at 255. It is cleared only by rst.
- Not defined: err_cnt tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset then 58 teeth of period 256 followed by a gap of period 768, filt_len=3, min_cap=128, max_cap=65535, teeth_last=57:
  - sync rises on the first gap edge with gap_stb and tooth_idx 0;
  - the next 57 edges give tooth_idx 1..57 with tooth_period 256;
  - the gap edge gives tooth_period 768.
- 2-cycle glitch on cap_in with filt_len=3 → cap_out unchanged, no strobes.
- Extra edge 50 cycles after a tooth while in SYNC → err_code 1; tooth_idx and sync unaffected.
- Remove cap_in toggling with max_cap=2000 → err_stb code 2 exactly 2000 cycles after the last edge; sync 0; FSM back to IDLE. Re-sync after the next gap.
- Gap arriving after tooth 40 while in SYNC → err_code 3, sync 0. Sync regained at the following valid gap.
- With HWAG_CAP_ERR_CNT_EN defined, 300 noise errors → err_cnt 255. Undefined → err_cnt stays 0.

Source files
------------

// File: rtl/hwag_cap_sync.sv
// Crank capture front end: synchronise, glitch-filter and edge-select the VR input, then time teeth and lock onto the 60-2 gap.
// Optional saturating error counter is built only when HWAG_CAP_ERR_CNT_EN is defined.
module hwag_cap_sync #(
  parameter int CNT_W   = 24,
  parameter int TOOTH_W = 8,
  parameter int FILT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_in,
  input  logic [FILT_W-1:0]  filt_len,
  input  logic               edge_sel,
  input  logic [CNT_W-1:0]   min_cap,
  input  logic [CNT_W-1:0]   max_cap,
  input  logic [TOOTH_W-1:0] teeth_last,
  output logic               cap_out,
  output logic               tooth_stb,
  output logic               gap_stb,
  output logic [TOOTH_W-1:0] tooth_idx,
  output logic [CNT_W-1:0]   tooth_period,
  output logic               sync,
  output logic               err_stb,
  output logic [1:0]         err_code,
  output logic [7:0]         err_cnt
);

  // state    | meaning
  // ST_IDLE  | no reference edge yet (after reset or stall)
  // ST_FIRST | one edge seen, waiting for first period
  // ST_HUNT  | measuring teeth, looking for the gap
  // ST_LOCK  | wheel position locked, counting teeth
  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_HUNT, ST_LOCK} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic [FILT_W:0]    filt_nxt;
  logic               cap_q, cap_d, cap_dly_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, prev_q, prev_d, period_q, period_d;
  logic [CNT_W:0]     gap_thr;
  logic [TOOTH_W-1:0] idx_q, idx_d;
  logic               tooth_stb_q, tooth_stb_d, gap_stb_q, gap_stb_d;
  logic               sync_q, sync_d, err_stb_q, err_stb_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               edge_c, stall, is_gap, is_short;

  always_comb begin
    filt_cnt_d = '0;
    cap_d      = cap_q;
    filt_nxt   = {1'b0, filt_cnt_q} + 1'b1;
    if (sync2_q != cap_q) begin
      if (filt_nxt >= {1'b0, filt_len}) cap_d = sync2_q;
      else                              filt_cnt_d = filt_nxt[FILT_W-1:0];
    end
  end

  assign edge_c   = edge_sel ? (~cap_q & cap_dly_q) : (cap_q & ~cap_dly_q);
  assign stall    = (state_q != ST_IDLE) && (cnt_q >= max_cap);
  assign gap_thr  = {1'b0, prev_q} + {1'b0, (prev_q >> 1)};
  assign is_gap   = {1'b0, cnt_q} > gap_thr;
  assign is_short = cnt_q < min_cap;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    prev_d      = prev_q;
    period_d    = period_q;
    idx_d       = idx_q;
    tooth_stb_d = 1'b0;
    gap_stb_d   = 1'b0;
    sync_d      = sync_q;
    err_stb_d   = 1'b0;
    err_code_d  = err_code_q;
    if (stall) begin
      err_stb_d  = 1'b1;
      err_code_d = 2'd2;
      sync_d     = 1'b0;
      state_d    = ST_IDLE;
    end else if (edge_c) begin
      // The counter is meaningless before the first reference edge, so IDLE takes any edge.
      if (state_q == ST_IDLE) begin
        cnt_d   = CNT_W'(1);
        state_d = ST_FIRST;
      end else if (is_short) begin
        err_stb_d  = 1'b1;
        err_code_d = 2'd1;
      end else begin
        cnt_d = CNT_W'(1);
        case (state_q)
          ST_FIRST: begin
            prev_d      = cnt_q;
            period_d    = cnt_q;
            idx_d       = '0;
            tooth_stb_d = 1'b1;
            state_d     = ST_HUNT;
          end
          ST_HUNT: begin
            period_d    = cnt_q;
            idx_d       = '0;
            tooth_stb_d = 1'b1;
            if (is_gap) begin
              gap_stb_d = 1'b1;
              sync_d    = 1'b1;
              state_d   = ST_LOCK;
            end else begin
              prev_d = cnt_q;
            end
          end
          ST_LOCK: begin
            if (is_gap && idx_q == teeth_last) begin
              period_d    = cnt_q;
              idx_d       = '0;
              tooth_stb_d = 1'b1;
              gap_stb_d   = 1'b1;
            end else if (is_gap || idx_q == teeth_last) begin
              // Early gap or missing gap: tooth count disagrees with the wheel.
              err_stb_d  = 1'b1;
              err_code_d = 2'd3;
              sync_d     = 1'b0;
              state_d    = ST_HUNT;
              if (!is_gap) prev_d = cnt_q;
            end else begin
              prev_d      = cnt_q;
              period_d    = cnt_q;
              idx_d       = idx_q + 1'b1;
              tooth_stb_d = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_cnt_q  <= '0;
      cap_q       <= 1'b0;
      cap_dly_q   <= 1'b0;
      cnt_q       <= '0;
      prev_q      <= '0;
      period_q    <= '0;
      idx_q       <= '0;
      tooth_stb_q <= 1'b0;
      gap_stb_q   <= 1'b0;
      sync_q      <= 1'b0;
      err_stb_q   <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= cap_in;
      sync2_q     <= sync1_q;
      filt_cnt_q  <= filt_cnt_d;
      cap_q       <= cap_d;
      cap_dly_q   <= cap_q;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      period_q    <= period_d;
      idx_q       <= idx_d;
      tooth_stb_q <= tooth_stb_d;
      gap_stb_q   <= gap_stb_d;
      sync_q      <= sync_d;
      err_stb_q   <= err_stb_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef HWAG_CAP_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_stb_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign cap_out      = cap_q;
  assign tooth_stb    = tooth_stb_q;
  assign gap_stb      = gap_stb_q;
  assign tooth_idx    = idx_q;
  assign tooth_period = period_q;
  assign sync         = sync_q;
  assign err_stb      = err_stb_q;
  assign err_code     = err_code_q;

endmodule
